// File: rtl/home_pkg.sv
// Shared types and constants for the home-automation sensor front-ends.
// Holds the ranger state encoding and the timing helpers used to size counters.
package home_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TRIG,
    ST_WAIT_RISE,
    ST_MEASURE,
    ST_HOLDOFF
  } ranger_state_t;

  // Round-trip echo time for one centimetre of range.
  localparam int US_PER_CM = 58;

  function automatic int us_cycles(input int freq);
    return freq / 1_000_000;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: one-cycle tick every DIV clocks.
// A synchronous clr restarts the count so the first tick lands DIV cycles later.
module us_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = (cnt_reg == LAST);

endmodule

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ranging front-end: periodic trigger, echo synchronisation and timing,
// and divider-free conversion of echo width to whole centimetres.
module hcsr04_ranger
  import home_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int TRIG_US    = 10,
  parameter int PERIOD_MS  = 60,
  parameter int TIMEOUT_US = 25000,
  parameter int MAX_CM     = 400
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        echo,
  output logic        trig,
  output logic [15:0] distance_cm,
  output logic        dist_stb,
  output logic        dist_valid,
  output logic        timeout,
  output logic        busy
);

  localparam int CYC_PER_US = us_cycles(CLK_FREQ);
  localparam int PERIOD_CYC = PERIOD_MS * (CLK_FREQ / 1000);
  localparam int PW         = $clog2(PERIOD_CYC + 1);
  localparam int US_MAX     = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
  localparam int UW         = $clog2(US_MAX + 2);

  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYC - 1);
  localparam logic [UW-1:0] TRIG_LAST   = UW'(TRIG_US - 1);
  localparam logic [UW-1:0] TIMEOUT_CNT = UW'(TIMEOUT_US);
  localparam logic [5:0]    SUB_LAST    = 6'(US_PER_CM - 1);
  localparam logic [15:0]   CM_MAX      = 16'(MAX_CM);

  ranger_state_t state_reg, state_next;

  logic          echo_s1_reg, echo_s2_reg, echo_s3_reg;
  logic          rise_reg, fall_reg;
  logic          us_tick, tick_clr, enter_trig;
  logic [PW-1:0] period_cnt_reg;
  logic [UW-1:0] us_cnt_reg, us_cnt_next;
  logic [5:0]    sub_cnt_reg, sub_cnt_next;
  logic [15:0]   cm_cnt_reg, cm_cnt_next;
  logic [15:0]   distance_reg, distance_next;
  logic          valid_reg, valid_next;
  logic          stb_reg, stb_next;
  logic          timeout_reg, timeout_next;
  logic          trig_reg;

  us_tick_gen #(
    .DIV(CYC_PER_US)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (tick_clr),
    .tick (us_tick)
  );

  assign enter_trig = (state_next == ST_TRIG) && (state_reg != ST_TRIG);
  assign tick_clr   = (state_next != state_reg) &&
                      (state_next == ST_TRIG || state_next == ST_WAIT_RISE ||
                       state_next == ST_MEASURE);

  always_comb begin
    state_next    = state_reg;
    us_cnt_next   = us_cnt_reg;
    sub_cnt_next  = sub_cnt_reg;
    cm_cnt_next   = cm_cnt_reg;
    distance_next = distance_reg;
    valid_next    = valid_reg;
    stb_next      = 1'b0;
    timeout_next  = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        if (enable) state_next = ST_TRIG;
      end
      ST_TRIG: begin
        if (us_tick) begin
          if (us_cnt_reg == TRIG_LAST) state_next = ST_WAIT_RISE;
          else us_cnt_next = us_cnt_reg + 1'b1;
        end
      end
      ST_WAIT_RISE: begin
        if (rise_reg) begin
          state_next = ST_MEASURE;
        end else if (us_cnt_reg == TIMEOUT_CNT) begin
          timeout_next = 1'b1;
          valid_next   = 1'b0;
          state_next   = ST_HOLDOFF;
        end else if (us_tick) begin
          us_cnt_next = us_cnt_reg + 1'b1;
        end
      end
      ST_MEASURE: begin
        // 58-tick sub-counter stands in for the divide by US_PER_CM.
        if (us_tick) begin
          us_cnt_next = us_cnt_reg + 1'b1;
          if (sub_cnt_reg == SUB_LAST) begin
            sub_cnt_next = '0;
            if (cm_cnt_reg != CM_MAX) cm_cnt_next = cm_cnt_reg + 1'b1;
          end else begin
            sub_cnt_next = sub_cnt_reg + 1'b1;
          end
        end
        if (fall_reg) begin
          distance_next = cm_cnt_next;
          stb_next      = 1'b1;
          valid_next    = 1'b1;
          state_next    = ST_HOLDOFF;
        end else if (us_cnt_reg == TIMEOUT_CNT) begin
          timeout_next = 1'b1;
          valid_next   = 1'b0;
          state_next   = ST_HOLDOFF;
        end
      end
      ST_HOLDOFF: begin
        if (period_cnt_reg == PERIOD_LAST) state_next = enable ? ST_TRIG : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // Every timed state starts its counters from zero.
    if (state_next != state_reg) begin
      us_cnt_next  = '0;
      sub_cnt_next = '0;
      cm_cnt_next  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      echo_s1_reg    <= 1'b0;
      echo_s2_reg    <= 1'b0;
      echo_s3_reg    <= 1'b0;
      rise_reg       <= 1'b0;
      fall_reg       <= 1'b0;
      period_cnt_reg <= '0;
      us_cnt_reg     <= '0;
      sub_cnt_reg    <= '0;
      cm_cnt_reg     <= '0;
      distance_reg   <= '0;
      valid_reg      <= 1'b0;
      stb_reg        <= 1'b0;
      timeout_reg    <= 1'b0;
      trig_reg       <= 1'b0;
    end else begin
      state_reg   <= state_next;
      echo_s1_reg <= echo;
      echo_s2_reg <= echo_s1_reg;
      echo_s3_reg <= echo_s2_reg;
      rise_reg    <= echo_s2_reg & ~echo_s3_reg;
      fall_reg    <= ~echo_s2_reg & echo_s3_reg;
      // Counted in clocks so trigger spacing is exact regardless of prescaler clears.
      if (enter_trig) period_cnt_reg <= '0;
      else if (period_cnt_reg != PERIOD_LAST) period_cnt_reg <= period_cnt_reg + 1'b1;
      us_cnt_reg   <= us_cnt_next;
      sub_cnt_reg  <= sub_cnt_next;
      cm_cnt_reg   <= cm_cnt_next;
      distance_reg <= distance_next;
      valid_reg    <= valid_next;
      stb_reg      <= stb_next;
      timeout_reg  <= timeout_next;
      trig_reg     <= (state_reg == ST_TRIG);
    end
  end

  assign trig        = trig_reg;
  assign distance_cm = distance_reg;
  assign dist_stb    = stb_reg;
  assign dist_valid  = valid_reg;
  assign timeout     = timeout_reg;
  assign busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Directed bench for hcsr04_ranger using three scaled-down instances:
// A = general timing and rounding, B = nominal 100 cm, C = saturation at MAX_CM=10.
module tb_hcsr04_ranger;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        en_w    [3];
  logic        echo_w  [3];
  logic        trig_w  [3];
  logic [15:0] dist_w  [3];
  logic        stb_w   [3];
  logic        valid_w [3];
  logic        to_w    [3];
  logic        busy_w  [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  hcsr04_ranger #(.CLK_FREQ(2_000_000), .TRIG_US(10), .PERIOD_MS(1), .TIMEOUT_US(400), .MAX_CM(400)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(en_w[0]), .echo(echo_w[0]), .trig(trig_w[0]),
    .distance_cm(dist_w[0]), .dist_stb(stb_w[0]), .dist_valid(valid_w[0]),
    .timeout(to_w[0]), .busy(busy_w[0]));

  hcsr04_ranger #(.CLK_FREQ(1_000_000), .TRIG_US(10), .PERIOD_MS(13), .TIMEOUT_US(6000), .MAX_CM(400)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(en_w[1]), .echo(echo_w[1]), .trig(trig_w[1]),
    .distance_cm(dist_w[1]), .dist_stb(stb_w[1]), .dist_valid(valid_w[1]),
    .timeout(to_w[1]), .busy(busy_w[1]));

  hcsr04_ranger #(.CLK_FREQ(1_000_000), .TRIG_US(10), .PERIOD_MS(3), .TIMEOUT_US(1200), .MAX_CM(10)) dut_c (
    .clk(clk), .rst_n(rst_n), .enable(en_w[2]), .echo(echo_w[2]), .trig(trig_w[2]),
    .distance_cm(dist_w[2]), .dist_stb(stb_w[2]), .dist_valid(valid_w[2]),
    .timeout(to_w[2]), .busy(busy_w[2]));

  typedef struct {
    int echo_us;
    int exp_cm;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // s: 0 trig, 1 dist_stb, 2 timeout, 3 busy
  function automatic logic sig(input int w, input int s);
    case (s)
      0:       return trig_w[w];
      1:       return stb_w[w];
      2:       return to_w[w];
      default: return busy_w[w];
    endcase
  endfunction

  task automatic wait_sig(input int w, input int s, input logic val, input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sig(w, s) !== val && n < limit);
  endtask

  task automatic wait_chk(input string name, input int w, input int s, input logic val,
                          input int limit, output int n);
    wait_sig(w, s, val, limit, n);
    chk({name, " reached"}, int'(sig(w, s) === val), 1);
  endtask

  // One full measurement: wait for a trigger, drive an echo of 'us' microseconds, check result.
  task automatic run_meas(input int w, input int div, input int us, input int exp_cm, input string tag);
    int n;
    int lat;
    wait_chk({tag, " trig rise"}, w, 0, 1'b1, 20000, n);
    wait_chk({tag, " trig fall"}, w, 0, 1'b0, 100, n);
    repeat (10) @(negedge clk);
    echo_w[w] = 1'b1;
    repeat (us * div) @(negedge clk);
    echo_w[w] = 1'b0;
    wait_sig(w, 1, 1'b1, 20, lat);
    chk({tag, " stb latency"}, lat, 4);
    chk({tag, " distance_cm"}, int'(dist_w[w]), exp_cm);
    chk({tag, " dist_valid"}, int'(valid_w[w]), 1);
    @(negedge clk);
    chk({tag, " stb one cycle"}, int'(stb_w[w]), 0);
    $display("%s: echo %0d us -> %0d cm, stb %0d clocks after echo fall", tag, us, dist_w[w], lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int t1;
    int t2;
    bit saw;

    vecs[0] = '{57, 0};
    vecs[1] = '{58, 1};
    vecs[2] = '{115, 1};
    vecs[3] = '{116, 2};
    vecs[4] = '{174, 3};
    vecs[5] = '{350, 6};

    for (int i = 0; i < 3; i++) begin
      en_w[i]   = 1'b0;
      echo_w[i] = 1'b0;
    end
    rst_n   = 1'b0;
    en_w[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset trig", int'(trig_w[0]), 0);
    chk("reset distance_cm", int'(dist_w[0]), 0);
    chk("reset dist_stb", int'(stb_w[0]), 0);
    chk("reset dist_valid", int'(valid_w[0]), 0);
    chk("reset timeout", int'(to_w[0]), 0);
    chk("reset busy", int'(busy_w[0]), 0);
    $display("reset held with enable=1: outputs trig=%0d busy=%0d", trig_w[0], busy_w[0]);

    // Asynchronous reset in the middle of the trigger pulse.
    rst_n = 1'b1;
    wait_chk("pre-reset trig rise", 0, 0, 1'b1, 10, n);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset trig", int'(trig_w[0]), 0);
    chk("async reset busy", int'(busy_w[0]), 0);
    chk("async reset stb", int'(stb_w[0]), 0);
    $display("reset asserted mid-TRIG: trig=%0d without clock edge", trig_w[0]);

    en_w[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle trig", int'(trig_w[0]), 0);
    chk("idle busy", int'(busy_w[0]), 0);

    // Enable to trig latency, trig width, no-echo timeout, trigger period.
    en_w[0] = 1'b1;
    wait_sig(0, 0, 1'b1, 10, n);
    chk("enable to trig clocks", n, 2);
    t1 = cyc;
    wait_sig(0, 0, 1'b0, 100, n);
    chk("trig high clocks", n, 20);
    wait_sig(0, 2, 1'b1, 1000, n);
    chk("timeout after trig fall", n, 800);
    chk("timeout clears dist_valid", int'(valid_w[0]), 0);
    chk("timeout without stb", int'(stb_w[0]), 0);
    wait_chk("second trig rise", 0, 0, 1'b1, 2100, n);
    t2 = cyc;
    chk("trig rise-to-rise clocks", t2 - t1, 2000);
    $display("trigger: width ok, period %0d clocks", t2 - t1);

    for (int i = 0; i < 6; i++) begin
      run_meas(0, 2, vecs[i].echo_us, vecs[i].exp_cm, $sformatf("vec%0d", i));
    end

    // Echo stuck high beyond the timeout: measurement abandoned, distance kept.
    wait_chk("stuck trig rise", 0, 0, 1'b1, 4000, n);
    wait_chk("stuck trig fall", 0, 0, 1'b0, 100, n);
    repeat (10) @(negedge clk);
    echo_w[0] = 1'b1;
    n   = 0;
    saw = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (stb_w[0]) saw = 1'b1;
    end while (!to_w[0] && n < 1100);
    chk_range("stuck echo timeout clocks", n, 800, 810);
    chk("stuck echo no stb", int'(saw), 0);
    chk("stuck echo dist_valid", int'(valid_w[0]), 0);
    chk("stuck echo distance kept", int'(dist_w[0]), vecs[5].exp_cm);
    @(negedge clk);
    chk("timeout one cycle", int'(to_w[0]), 0);
    echo_w[0] = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (stb_w[0]) saw = 1'b1;
    end
    chk("late echo fall ignored", int'(saw), 0);
    $display("stuck echo: timeout after %0d clocks, distance %0d kept", n, dist_w[0]);

    // Enable dropped mid-measurement still delivers, then parks in IDLE.
    wait_chk("drop trig rise", 0, 0, 1'b1, 4000, n);
    wait_chk("drop trig fall", 0, 0, 1'b0, 100, n);
    repeat (10) @(negedge clk);
    echo_w[0] = 1'b1;
    repeat (100) @(negedge clk);
    en_w[0] = 1'b0;
    repeat (100) @(negedge clk);
    echo_w[0] = 1'b0;
    wait_sig(0, 1, 1'b1, 20, n);
    chk("drop stb latency", n, 4);
    chk("drop distance_cm", int'(dist_w[0]), 1);
    chk("drop dist_valid", int'(valid_w[0]), 1);
    wait_chk("drop busy low", 0, 3, 1'b0, 2500, n);
    saw = 1'b0;
    repeat (2500) begin
      @(negedge clk);
      if (trig_w[0]) saw = 1'b1;
    end
    chk("no trig after enable drop", int'(saw), 0);
    chk("idle after enable drop", int'(busy_w[0]), 0);
    $display("enable drop: distance %0d delivered, busy=%0d", dist_w[0], busy_w[0]);

    en_w[1] = 1'b1;
    run_meas(1, 1, 5800, 100, "nominal");
    en_w[1] = 1'b0;

    en_w[2] = 1'b1;
    run_meas(2, 1, 1000, 10, "saturate");
    en_w[2] = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
